or_gate_sequencer: RTL and testbench

OR_GATE_SEQUENCER -- requirements
Module: or_gate_sequencer

---
 rtl/or_seq_pkg.sv | 24 ++
 rtl/or_gate_sequencer_settle_timer.sv | 28 ++
 rtl/or_gate_sequencer.sv | 107 ++++++++++
 tb/tb_or_gate_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or_seq_pkg.sv
// Shared types and constants for the OR gate sequencer.
// Optional stop-on-error mode: OR_SEQ_STOP_ON_ERR_EN.
package or_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int ERR_W       = 3;
    localparam int IDX_W       = 2;
    localparam int CNT_W       = 4;

    localparam logic [ERR_W-1:0] ERR_MAX = 3'd4;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v >= ERR_MAX) ? ERR_MAX : v + 1'b1;
    endfunction

endpackage

// File: rtl/or_gate_sequencer_settle_timer.sv
// Down-counter that times the SETTLE wait of the OR gate sequencer.
// Loaded while a vector is applied, counts down while settling.
module settle_timer
    import or_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = en && (count == '0);

endmodule

// File: rtl/or_gate_sequencer.sv
// Drives the four OR truth-table vectors to an external gate and checks Y.
// Define OR_SEQ_STOP_ON_ERR_EN to end a run at the first mismatch.
module or_gate_sequencer
    import or_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             Y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] vec_idx
);

    state_t           state;
    state_t           state_n;
    logic             drive;
    logic             expired;
    logic             mismatch;
    logic             last_vec;
    logic [ERR_W-1:0] err_next;

    settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == APPLY),
        .en       (state == SETTLE),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .expired  (expired)
    );

    // Operands are only presented while a vector is in flight.
    assign drive = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign A     = drive & vec_idx[1];
    assign B     = drive & vec_idx[0];
    assign busy  = drive;
    assign done  = (state == DONE);

    assign mismatch = (state == CHECK) && (Y != (A | B));
    assign last_vec = (vec_idx == IDX_W'(NUM_VECTORS - 1));
    assign err_next = mismatch ? sat_inc(err_count) : err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = APPLY;
            end
            APPLY: begin
                state_n = SETTLE;
            end
            SETTLE: begin
                if (expired) state_n = CHECK;
            end
            CHECK: begin
`ifdef OR_SEQ_STOP_ON_ERR_EN
                if (mismatch || last_vec) state_n = DONE;
                else                      state_n = APPLY;
`else
                if (last_vec) state_n = DONE;
                else          state_n = APPLY;
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_idx   <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                vec_idx   <= '0;
                err_count <= '0;
                pass      <= 1'b0;
            end
            if (state == CHECK) begin
                err_count <= err_next;
                if (state_n == APPLY) vec_idx <= vec_idx + 1'b1;
                // Verdict must already be valid in the DONE cycle.
                if (state_n == DONE) pass <= (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_or_gate_sequencer.sv
// Scoreboard bench for or_gate_sequencer with a fault-injecting OR gate.
// Also times runs on SETTLE_CYCLES=1 and SETTLE_CYCLES=15 instances.
module tb_or_gate_sequencer;
    import or_seq_pkg::*;

    localparam int S0 = 2;

    logic clk = 1'b0;
    logic rst;
    logic start0;
    logic a0, b0, y0, busy0, done0, pass0;
    logic [ERR_W-1:0] err0;
    logic [1:0] idx0;
    logic [3:0] mask;

    logic [2:1] st, aa, ba, bu, dn, pa;
    logic [ERR_W-1:0] er1, er2;
    logic [1:0] ix1, ix2;

    // Faulty gate: mask bit v inverts the result for vector v = {A,B}.
    assign y0 = (a0 | b0) ^ mask[{a0, b0}];

    or_gate_sequencer #(.SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .A(a0), .B(b0), .Y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .vec_idx(idx0)
    );

    or_gate_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .A(aa[1]), .B(ba[1]),
        .Y(aa[1] | ba[1]), .busy(bu[1]), .done(dn[1]), .pass(pa[1]),
        .err_count(er1), .vec_idx(ix1)
    );

    or_gate_sequencer #(.SETTLE_CYCLES(15)) dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .A(aa[2]), .B(ba[2]),
        .Y(aa[2] | ba[2]), .busy(bu[2]), .done(dn[2]), .pass(pa[2]),
        .err_count(er2), .vec_idx(ix2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int start;
        int len;
        int err;
        int pass;
        int idx;
    } run_t;

    run_t q[$];
    run_t last;

    // Expected outcome from the truth table and the fault mask alone.
    function automatic run_t model(input int s, input logic [3:0] m,
                                   input int st_cyc);
        run_t r;
        int n;
        n = 0;
        r.err = 0;
        r.idx = 0;
        for (int v = 0; v < NUM_VECTORS; v++) begin
            r.idx = v;
            n++;
            if (m[v]) r.err = (r.err < 4) ? r.err + 1 : 4;
`ifdef OR_SEQ_STOP_ON_ERR_EN
            if (r.err != 0) break;
`endif
        end
        r.len   = n * (s + 2);
        r.pass  = (r.err == 0) ? 1 : 0;
        r.start = st_cyc;
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        bit run_now;
        bit done_now;
        int k;
        if (!rst) begin
            run_now  = q.size() > 0 && cyc >= q[0].start &&
                       cyc < q[0].start + q[0].len;
            done_now = q.size() > 0 && cyc == q[0].start + q[0].len;
            chk("busy", busy0, run_now);
            chk("done", done0, done_now);
            if (run_now) begin
                k = (cyc - q[0].start) / (S0 + 2);
                chk("ab_run", {a0, b0}, k);
                chk("vec_idx_run", idx0, k);
                chk("pass_run", pass0, 0);
            end else if (done_now) begin
                chk("ab_done", {a0, b0}, 0);
                chk("err_done", err0, q[0].err);
                chk("pass_done", pass0, q[0].pass);
                chk("vec_idx_done", idx0, q[0].idx);
                last = q[0];
                void'(q.pop_front());
            end else begin
                chk("ab_idle", {a0, b0}, 0);
                chk("err_idle", err0, last.err);
                chk("pass_idle", pass0, last.pass);
                chk("vec_idx_idle", idx0, last.idx);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run0(input logic [3:0] m, input int gap);
        run_t r;
        mask = m;
        r = model(S0, m, cyc + 1);
        q.push_back(r);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(r.len + 1 + gap);
    endtask

    task automatic len_check(input int w, input int s);
        int n;
        int k;
        bit seen;
        n = 0;
        k = 0;
        seen = 0;
        st[w] = 1'b1;
        tick(1);
        st[w] = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bu[w]) begin
                chk($sformatf("ab_s%0d", s), {aa[w], ba[w]}, k / (s + 2));
                k++;
            end
            if (dn[w]) begin
                seen = 1;
                chk($sformatf("pass_s%0d", s), pa[w], 1);
                chk($sformatf("err_s%0d", s), (w == 1) ? er1 : er2, 0);
                chk($sformatf("idx_s%0d", s), (w == 1) ? ix1 : ix2, 3);
            end
        end
        chk($sformatf("done_seen_s%0d", s), seen, 1);
        chk($sformatf("busy_len_s%0d", s), k, 4 * (s + 2));
        chk($sformatf("done_lat_s%0d", s), n, 4 * (s + 2) + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_a"}, a0, 0);
        chk({tag, "_b"}, b0, 0);
        chk({tag, "_pass"}, pass0, 0);
        chk({tag, "_err"}, err0, 0);
        chk({tag, "_idx"}, idx0, 0);
        chk({tag, "_busy_others"}, bu, 0);
        chk({tag, "_done_others"}, dn, 0);
    endtask

    initial begin
        run_t r;
        run_t r2;
        logic [3:0] m;
        rst = 1'b1;
        start0 = 1'b0;
        st = '0;
        mask = '0;
        last = '{0, 0, 0, 0, 0};
        tick(2);
        reset_checks("rst_init");
        rst = 1'b0;
        tick(3);

        run0(4'b0000, 2);
        run0(4'b1110, 1);
        run0(4'b0001, 1);

        // Reset during the first SETTLE cycle of vector 2.
        mask = 4'b0000;
        q.push_back(model(S0, mask, cyc + 1));
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(9);
        chk("pre_rst_idx", idx0, 2);
        q.delete();
        last = '{0, 0, 0, 0, 0};
        rst = 1'b1;
        #1;
        reset_checks("rst_mid");
        tick(1);
        rst = 1'b0;
        tick(4);
        run0(4'b0000, 1);

        // Start pulses during a run and during DONE must be ignored.
        mask = 4'b0000;
        r = model(S0, mask, cyc + 1);
        q.push_back(r);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(5);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(r.len - 6);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(4);

        // Held start: second run begins after one IDLE cycle.
        m = 4'($urandom_range(0, 15));
        mask = m;
        r = model(S0, m, cyc + 1);
        r2 = model(S0, m, r.start + r.len + 2);
        q.push_back(r);
        q.push_back(r2);
        start0 = 1'b1;
        tick(1);
        tick(r.len + 2);
        start0 = 1'b0;
        tick(r2.len + 3);

        repeat (12) begin
            run0(4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        len_check(1, 1);
        len_check(2, 15);

        tick(5);
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
